// File: rtl/apb_node_pkg.sv
// Shared types and width helpers for the registered APB demultiplexer.
// Combinational only; no latency, no flow control.
// Provides the FSM state enum and helper functions that size the parameter-derived fields.
package apb_node_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // A watchdog of 0 cycles still needs one counter bit to stay legal.
    function automatic int cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int nb_master);
        return (nb_master > 1) ? $clog2(nb_master) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Address-window decoder: inclusive unsigned start/end windows, lowest index wins on overlap.
// Combinational, zero latency.
// No flow control; the result follows addr and the window config directly.
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int NB_MASTER      = 8,
    parameter int APB_ADDR_WIDTH = 32,
    localparam int IDX_W         = idx_width(NB_MASTER)
) (
    input  logic [APB_ADDR_WIDTH-1:0]                addr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr,
    output logic                                     hit,
    output logic [IDX_W-1:0]                         idx
);

    logic [NB_MASTER-1:0] hits;

    always_comb begin
        hits = '0;
        idx  = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            hits[i] = (addr >= start_addr[i]) && (addr <= end_addr[i]);
        end
        // Scan downwards so the lowest matching window is the last one written.
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (hits[i]) idx = IDX_W'(i);
        end
    end

    assign hit = |hits;

endmodule

// File: rtl/apb_node_sync.sv
// Registered APB 1-to-N demux with decode-miss errors, overlap priority and an ACCESS watchdog.
// Latency: hit = 3 cycles plus downstream wait states; decode miss = 1 cycle.
// Backpressure: upstream is held via pready_o; downstream wait states stretch ACCESS until pready_i or timeout.
module apb_node_sync
    import apb_node_pkg::*;
#(
    parameter int NB_MASTER      = 8,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH    = strb_width(APB_DATA_WIDTH)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     psel_i,
    input  logic                                     penable_i,
    input  logic                                     pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
    input  logic [STRB_WIDTH-1:0]                    pstrb_i,
    output logic [APB_DATA_WIDTH-1:0]                prdata_o,
    output logic                                     pready_o,
    output logic                                     pslverr_o,
    output logic [NB_MASTER-1:0]                     psel_o,
    output logic                                     penable_o,
    output logic                                     pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
    output logic [STRB_WIDTH-1:0]                    pstrb_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_MASTER-1:0]                     pready_i,
    input  logic [NB_MASTER-1:0]                     pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i,
    output logic                                     err_decode_o,
    output logic                                     err_timeout_o
);

    localparam int IDX_W = idx_width(NB_MASTER);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     strb_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      err_decode_q;
    logic                      err_timeout_q;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic                      start_req;
    logic                      timeout_hit;

    apb_addr_decoder #(
        .NB_MASTER      (NB_MASTER),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
    ) u_decoder (
        .addr       (paddr_i),
        .start_addr (START_ADDR_i),
        .end_addr   (END_ADDR_i),
        .hit        (dec_hit),
        .idx        (dec_idx)
    );

    assign start_req   = psel_i && !penable_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        psel_o    = '0;
        penable_o = 1'b0;
        pwrite_o  = 1'b0;
        paddr_o   = '0;
        pwdata_o  = '0;
        pstrb_o   = '0;
        pready_o  = 1'b0;
        prdata_o  = '0;
        pslverr_o = 1'b0;

        case (state_q)
            IDLE:    if (start_req) state_d = dec_hit ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i[idx_q] || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == SETUP || state_q == ACCESS) begin
            psel_o    = NB_MASTER'(1) << idx_q;
            penable_o = (state_q == ACCESS);
            pwrite_o  = write_q;
            paddr_o   = addr_q;
            pwdata_o  = wdata_q;
            pstrb_o   = strb_q;
        end

        if (state_q == RESP) begin
            pready_o  = 1'b1;
            prdata_o  = rdata_q;
            pslverr_o = err_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            idx_q         <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            err_decode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_decode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        addr_q       <= paddr_i;
                        write_q      <= pwrite_i;
                        wdata_q      <= pwdata_i;
                        strb_q       <= pwrite_i ? pstrb_i : '0;
                        idx_q        <= dec_idx;
                        rdata_q      <= '0;
                        err_q        <= !dec_hit;
                        err_decode_q <= !dec_hit;
                    end
                end
                SETUP: cnt_q <= '0;
                ACCESS: begin
                    // Read data is only returned for clean reads; writes and errors return zero.
                    if (pready_i[idx_q]) begin
                        rdata_q <= (write_q || pslverr_i[idx_q]) ? '0 : prdata_i[idx_q];
                        err_q   <= pslverr_i[idx_q];
                    end else if (timeout_hit) begin
                        rdata_q       <= '0;
                        err_q         <= 1'b1;
                        err_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_decode_o  = err_decode_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: doc/apb_node_sync.md
Name: apb_node_sync

Overview:
Registered, parametrised APB demultiplexer: one upstream APB slave port fans out to NB_MASTER downstream APB slaves selected by programmable address windows. It registers the request, runs a full downstream SETUP/ACCESS sequence, and returns a registered response. It adds behaviour the combinational node lacks:
- decode-miss error response
- overlap priority (lowest index wins)
- downstream timeout watchdog
- APB4 write strobes
- configurable data and address widths

It sits between the SoC APB bridge and the peripheral cluster.

Parameters:
NB_MASTER, 8, number of downstream ports (1..32)
APB_ADDR_WIDTH, 32, address width of the upstream port, downstream ports and window config
APB_DATA_WIDTH, 32, data width (multiple of 8); STRB_WIDTH = APB_DATA_WIDTH/8
TIMEOUT_CYCLES, 256, maximum downstream ACCESS cycles before a forced error; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
psel_i  in  1  upstream select
penable_i  in  1  upstream enable
pwrite_i  in  1  upstream write
paddr_i  in  APB_ADDR_WIDTH  upstream address
pwdata_i  in  APB_DATA_WIDTH  upstream write data
pstrb_i  in  STRB_WIDTH  upstream write strobes
prdata_o  out  APB_DATA_WIDTH  upstream read data
pready_o  out  1  upstream ready
pslverr_o  out  1  upstream error
psel_o  out  NB_MASTER  one-hot downstream select
penable_o  out  1  downstream enable (shared)
pwrite_o  out  1  downstream write (shared)
paddr_o  out  APB_ADDR_WIDTH  downstream address (shared)
pwdata_o  out  APB_DATA_WIDTH  downstream write data (shared)
pstrb_o  out  STRB_WIDTH  downstream strobes (shared)
prdata_i  in  NB_MASTER x APB_DATA_WIDTH  downstream read data
pready_i  in  NB_MASTER  downstream ready
pslverr_i  in  NB_MASTER  downstream error
START_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive window start
END_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive window end
err_decode_o  out  1  one-cycle pulse on decode miss
err_timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; all outputs are 0; request, response and counter registers are 0.
- Decode (combinational on paddr_i): hit[i] = START_ADDR_i[i] <= paddr_i <= END_ADDR_i[i], unsigned comparison. The selected index is the lowest set hit bit. No hit means a miss.
- IDLE:
  - Starts only when psel_i=1 and penable_i=0.
  - Captures paddr, pwrite, pwdata, pstrb (pstrb forced to 0 on reads), selected index and hit/miss.
  - Next state: SETUP on hit; RESP with err=1 and rdata=0 on miss, with err_decode_o pulsed in the same cycle RESP is entered.
  - psel_i=1 with penable_i=1 while in IDLE is ignored.
- SETUP (1 cycle): psel_o[idx]=1, penable_o=0, shared buses driven from registers. Watchdog counter is cleared. Next: ACCESS.
- ACCESS: psel_o[idx]=1, penable_o=1, buses held stable.
  - pready_i[idx]=1: register prdata_i[idx] and pslverr_i[idx], go to RESP.
  - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: go to RESP with err=1 and rdata=0, pulse err_timeout_o. psel_o and penable_o drop on the next cycle.
  - Otherwise counter increments.
- RESP (1 cycle): pready_o=1, prdata_o=registered data (0 for writes and errors), pslverr_o=registered err. Next: IDLE.
- Outside RESP: pready_o=0, prdata_o=0, pslverr_o=0.
- Outside SETUP/ACCESS: psel_o=0, penable_o=0, shared buses=0.
- Latency:
  - Hit with zero downstream wait: upstream setup at cycle 0, pready_o at cycle 3.
  - Decode miss: pready_o at cycle 1.
  - Downstream wait states add 1:1.
- Upstream must hold psel_i, penable_i and its payload until pready_o. The node reads the payload only in IDLE.
- Back-to-back: after RESP, a new setup is accepted in the following IDLE cycle; there is no extra bubble.
- Window config is sampled only at decode; changes mid-transfer have no effect on that transfer.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Package apb_node_pkg: FSM state enum (IDLE, SETUP, ACCESS, RESP) and the localparam functions for STRB_WIDTH and counter width.
- One sub-module, apb_addr_decoder: combinational windows-to-{hit, idx}, parametrised on NB_MASTER and APB_ADDR_WIDTH, with lowest-index priority. Reusable by other interconnect blocks.

Test Plan:
- Write hit: windows[2]=0x1A102000..0x1A102FFF; write 0xDEADBEEF with strb 0xF to 0x1A102010, pready_i[2]=1 immediately -> psel_o=0x04, pwdata_o=0xDEADBEEF, pready_o at cycle 3, pslverr_o=0.
- Read with wait states: slave 5 holds pready_i low for 4 ACCESS cycles, prdata_i[5]=0x12345678 -> pready_o at cycle 7, prdata_o=0x12345678; pstrb_o=0 throughout.
- Decode miss: read 0xFFFF0000 with no matching window -> no psel_o activity, pready_o=1 and pslverr_o=1 at cycle 1, prdata_o=0, err_decode_o pulses once.
- Overlap: windows 1 and 3 both cover 0x1000 -> only psel_o[1] asserted; pslverr_i[1]=1 propagates to pslverr_o=1.
- Timeout: TIMEOUT_CYCLES=8, target never readies -> exactly 8 ACCESS cycles, then psel_o=0, err_timeout_o pulse, pslverr_o=1, prdata_o=0.
- Reset in ACCESS: assert rst_i mid-wait -> all outputs 0 asynchronously; after release, a new read completes normally.
